// File: rtl/timer_pkg.sv
// Shared definitions for the timer sequencer: FSM state encoding and c_enable bit positions.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10,
    DONE = 2'b11
  } state_t;

  localparam int EN_BIT          = 0;
  localparam int AUTO_RELOAD_BIT = 1;
  localparam int IRQ_EN_BIT      = 2;
  localparam int PRESCALE_LSB    = 4;
  localparam int PRESCALE_MSB    = 7;

endpackage

// File: rtl/timer_prescaler.sv
// 4-bit tick divider: o_tick is high one cycle in every i_div+1, combinationally from the count.
// i_clr restarts the division so the first tick after a clear comes i_div+1 cycles later.
module timer_prescaler (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clr,
  input  logic [3:0] i_div,
  output logic       o_tick
);

  logic [3:0] r_cnt;
  logic       w_wrap;

  // >= rather than == so a divisor lowered mid-count wraps immediately instead of after 16.
  assign w_wrap = (r_cnt >= i_div);
  assign o_tick = ~i_clr & w_wrap;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/timer_sched.sv
// Timer sequencer: load / countdown / expiry / auto-reload with sticky maskable IRQ; expiry N+1 cycles after EN.
// Define TIMER_PRESCALE_EN to divide ticks by c_enable[7:4]+1; otherwise every cycle is a tick.
module timer_sched
  import timer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic [WIDTH-1:0] timer_in,
  input  logic [7:0]       c_enable,
  input  logic             load_stb,
  input  logic             irq_clr,
  output logic [WIDTH-1:0] count,
  output logic             expired,
  output logic             irq,
  output logic             busy,
  output logic [1:0]       state
);

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  logic             r_expired;
  logic             r_irq_pend;
  logic             r_busy;

  logic w_en;
  logic w_auto;
  logic w_tick;
  logic w_last;
  logic w_expire;

  assign w_en   = c_enable[EN_BIT];
  assign w_auto = c_enable[AUTO_RELOAD_BIT];
  assign w_last = (r_count == WIDTH'(1));

`ifdef TIMER_PRESCALE_EN
  logic w_pre_clr;
  logic w_cen_unused;
  assign w_pre_clr    = ~w_en | (r_state == LOAD);
  assign w_cen_unused = c_enable[3];

  timer_prescaler u_prescaler (
    .i_clk  (PCLK),
    .i_rst  (PRESET),
    .i_clr  (w_pre_clr),
    .i_div  (c_enable[PRESCALE_MSB:PRESCALE_LSB]),
    .o_tick (w_tick)
  );
`else
  logic w_cen_unused;
  assign w_cen_unused = ^c_enable[PRESCALE_MSB:3];
  assign w_tick       = 1'b1;
`endif

  // Terminal event: zero reload seen in LOAD, or the last tick of a countdown; EN=0 suppresses it.
  assign w_expire = w_en &&
                    (((r_state == LOAD) && (r_reload == '0)) ||
                     ((r_state == RUN) && w_tick && w_last));

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_reload  <= '0;
      r_expired <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_expired <= w_expire;
      if (load_stb) begin
        r_reload <= timer_in;
      end
      if (!w_en) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: r_state <= LOAD;
          LOAD: begin
            r_count <= r_reload;
            if (r_reload == '0) begin
              r_state <= DONE;
            end else begin
              r_state <= RUN;
              r_busy  <= 1'b1;
            end
          end
          RUN: begin
            if (w_tick) begin
              if (!w_last) begin
                r_count <= r_count - WIDTH'(1);
              end else if (w_auto && (r_reload != '0)) begin
                r_count <= r_reload;
              end else begin
                r_count <= '0;
                r_state <= DONE;
                r_busy  <= 1'b0;
              end
            end
          end
          DONE: begin
            r_count <= '0;
            if (load_stb) begin
              r_state <= LOAD;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // A clear arriving alongside the expiry edge or during the visible pulse never wins.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_irq_pend <= 1'b0;
    end else begin
      r_irq_pend <= w_expire | r_expired | (r_irq_pend & ~irq_clr);
    end
  end

  assign count   = r_count;
  assign expired = r_expired;
  assign irq     = r_irq_pend & c_enable[IRQ_EN_BIT];
  assign busy    = r_busy;
  assign state   = r_state;

endmodule

// File: doc/timer_sched.md
# timer_sched

Timer sequencer sitting between the APB register slave and the countdown datapath. Consumes the `timer_in` reload value and `c_enable` control byte written over APB. Sequences load, countdown, expiry and optional auto-reload. Raises a maskable, sticky interrupt toward the system.

## Interface
Parameters:
- `WIDTH`, 8: counter and reload width.

Ports:
- `PCLK`, in, 1: sole clock, rising edge.
- `PRESET`, in, 1: reset, asynchronous, active-high.
- `timer_in`, in, WIDTH: reload value from the APB register.
- `c_enable`, in, 8: control byte. Bit 0 EN, bit 1 AUTO_RELOAD, bit 2 IRQ_EN, bits 7:4 PRESCALE.
- `load_stb`, in, 1: one-cycle pulse when APB writes `timer_in`.
- `irq_clr`, in, 1: one-cycle pulse that clears the pending interrupt.
- `count`, out, WIDTH: current counter value.
- `expired`, out, 1: one-cycle pulse on terminal count.
- `irq`, out, 1: interrupt level, equal to `irq_pend & IRQ_EN`.
- `busy`, out, 1: high while state is RUN.
- `state`, out, 2: FSM state, for debug.

## Operation
- **Reset values:** state IDLE; `count`, `reload_r`, `irq_pend`, `expired`, `busy` all 0.
- **Reload capture:** `load_stb` captures `timer_in` into `reload_r` on the next edge, in any state.
- **Mid-run reload writes:** a write during RUN takes effect only at the next reload.
- **States:**
  - IDLE: `count` holds its value. EN=1 goes to LOAD.
  - LOAD: `count <= reload_r`. If `reload_r == 0`, go to DONE and pulse `expired`. Otherwise go to RUN. The prescaler is cleared.
  - RUN: `count` decrements on each tick. At a tick with `count == 1`, pulse `expired`:
    - AUTO_RELOAD=1: `count <= reload_r` and stay in RUN.
    - AUTO_RELOAD=0: `count <= 0` and go to DONE.
  - DONE: `count` holds 0. `load_stb` with EN=1 goes to LOAD.
- **EN priority:** EN=0 in any state goes to IDLE on the next edge, and `count` freezes. Re-enabling restarts from LOAD; there is no resume.
- **Zero reload:** always ends in DONE, even with AUTO_RELOAD=1. This prevents an expiry storm.
- **Interrupt:**
  - `irq_pend` sets on `expired`. Set and `irq_clr` in the same cycle leaves it set (set wins).
  - `irq_pend` is sticky and is not cleared by EN=0.
  - IRQ_EN only masks the `irq` output.
- **Same-cycle reload:** `load_stb` coincident with an auto-reload expiry uses the old `reload_r`. The new value applies from the following reload.
- **Arithmetic:** unsigned, no underflow possible (terminal value is 1).

## Timing
- EN sampled high at edge k, from IDLE:
  - LOAD after k.
  - `count = N` and state RUN after k+1.
  - Without prescale, `count = N-j` after edge k+1+j.
  - `expired` and `irq_pend` high after edge k+N+1.
- One-shot latency: N+1 cycles from EN sample to `expired`.
- Auto-reload period: exactly N·(P+1) cycles between `expired` pulses.
- `expired` lasts exactly one cycle. `irq` follows `irq_pend` combinationally through the mask.
- `PRESET` asserted mid-operation forces all outputs to reset values immediately, with no edge needed.

## Configuration
- Macro: `TIMER_PRESCALE_EN`.
- Defined: one tick every P+1 PCLK cycles, where P = `c_enable[7:4]`. The prescale counter clears in LOAD and on EN=0.
- Undefined: one tick every cycle, and `c_enable[7:4]` is ignored.

## Structure
- Package `timer_pkg` holds:
  - state localparams: IDLE=2'b00, LOAD=2'b01, RUN=2'b10, DONE=2'b11.
  - `c_enable` bit index constants: EN, AUTO_RELOAD, IRQ_EN, PRESCALE_LSB/MSB.
- Sub-module `timer_prescaler`: 4-bit divider producing a `tick` pulse, with a clear input. It is instantiated only under `TIMER_PRESCALE_EN`; otherwise tick=1.

## Test plan
- Reset, `load_stb` with `timer_in`=5, `c_enable`=8'h05 (EN, IRQ_EN, one-shot) -> `count` 5,4,3,2,1,0; single `expired` 6 edges after EN sample; state DONE; `irq`=1.
- `timer_in`=3, `c_enable`=8'h03 -> `count` 3,2,1,3,2,1…; `expired` every 3 cycles; `irq`=0 since masked; `irq_pend`=1.
- `irq_clr` coincident with `expired` -> `irq` stays 1. `irq_clr` alone -> `irq`=0 next cycle.
- EN dropped at `count`=2 -> IDLE, `count` holds 2. EN=1 again -> LOAD, `count`=reload.
- `timer_in`=0, AUTO_RELOAD=1 -> DONE after LOAD, exactly one `expired`. `PRESET` mid-RUN -> all outputs 0 immediately.
- `TIMER_PRESCALE_EN` defined, P=1, `timer_in`=4 -> decrement every 2 cycles; `expired` after 8 RUN cycles.
